audio_capture_mc: RTL and testbench

Multi-channel, single-clock audio capture bridge between the synth voice/mixer output and the HPS over an Avalon-MM slave. Each sample strobe captures one frame of NCH channels into an on-chip frame FIFO. Software drains the FIFO one channel word per read. A threshold/overflow interrupt paces the drain. This block generalises the stereo-only capture path to N channels, programmable depth and IRQ level, sign-extension mode, and overflow/underflow reporting.

---
 rtl/audio_capture_pkg.sv | 24 ++
 rtl/frame_fifo.sv | 77 +++++++
 rtl/audio_capture_mc.sv | 169 ++++++++++++++++
 tb/tb_audio_capture_mc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_capture_pkg.sv
// Shared constants for the multi-channel audio capture bridge.
// Holds the Avalon register map and the bit positions inside CTRL and STATUS.
package audio_capture_pkg;

    typedef enum int {
        REG_CTRL   = 0,
        REG_STATUS = 1,
        REG_THRESH = 2,
        REG_DATA   = 3,
        REG_CHIDX  = 4
    } reg_addr_e;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;
    localparam int CTRL_SEXT   = 3;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;
    localparam int ST_UDF   = 19;
    localparam int ST_IRQ   = 20;

endpackage

// File: rtl/frame_fifo.sv
// Show-ahead frame FIFO. The head frame is held in a register, so the oldest
// frame is always visible. Frames behind it live in a synchronous-read RAM.
// Ports: clk, reset_n (sync, active-low), push/din, pop, flush,
//        full, empty, level (frames held, head included), head.
module frame_fifo #(
    parameter int WIDTH = 48,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic [WIDTH-1:0] head
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      ram_cnt;
    logic             head_valid;
    logic             push_ok;
    logic             take;
    logic             ram_has;
    logic             ram_wr;
    logic             ram_rd;

    assign level   = ram_cnt + (AW+1)'(head_valid);
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = !head_valid;
    // A push against a full FIFO is still accepted when the head leaves this cycle.
    assign push_ok = push && (!full || pop);
    // The head register reloads whenever it is empty or being consumed.
    assign take    = !head_valid || pop;
    assign ram_has = (ram_cnt != '0);
    assign ram_rd  = take && ram_has;
    // With nothing queued in RAM, an incoming frame goes straight to the head.
    assign ram_wr  = push_ok && !(take && !ram_has);

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            head <= ram_has ? mem[rd_ptr] : din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            head_valid <= 1'b0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            ram_cnt <= ram_cnt + (AW+1)'(ram_wr) - (AW+1)'(ram_rd);
            if (take) begin
                head_valid <= ram_has || push_ok;
            end
        end
    end

endmodule

// File: rtl/audio_capture_mc.sv
// Multi-channel audio capture bridge: frames strobed in by the mixer are
// queued in a frame FIFO and drained one channel word per Avalon DATA read.
// Ports: clk, reset_n (sync, active-low), Avalon-MM slave (address,
//        chipselect, read, write, writedata, readdata, irq), con_sample_valid,
//        con_sound_in (NCH packed channels), con_capture_en (CTRL.run).
module audio_capture_mc
    import audio_capture_pkg::*;
#(
    parameter int NCH           = 2,
    parameter int AUD_BIT_DEPTH = 24,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_WIDTH    = 6,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDRESS_WIDTH-1:0]     slave_address,
    input  logic                         slave_chipselect,
    input  logic                         slave_read,
    input  logic                         slave_write,
    input  logic [DATA_WIDTH-1:0]        slave_writedata,
    output logic [DATA_WIDTH-1:0]        slave_readdata,
    output logic                         slave_irq,
    input  logic                         con_sample_valid,
    input  logic [NCH*AUD_BIT_DEPTH-1:0] con_sound_in,
    output logic                         con_capture_en
);
    localparam int FW = NCH * AUD_BIT_DEPTH;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                     run;
    logic                     irq_en;
    logic                     sext;
    logic [FIFO_WIDTH:0]      thresh;
    logic                     ovf;
    logic                     udf;
    logic                     irq_q;
    logic [CW-1:0]            chidx;

    logic                     wr_en;
    logic                     rd_en;
    logic                     flush;
    logic                     data_rd;
    logic                     last_ch;
    logic                     fifo_pop;
    logic                     push_req;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_WIDTH:0]      fifo_level;
    logic [FW-1:0]            fifo_head;
    logic [AUD_BIT_DEPTH-1:0] ch_word;
    logic [DATA_WIDTH-1:0]    data_word;
    logic [DATA_WIDTH-1:0]    rd_mux;
    logic [63:0]              reg_word;
    logic                     irq_cond;
    logic                     unused_wdata;

    assign wr_en    = slave_chipselect && slave_write;
    assign rd_en    = slave_chipselect && slave_read;
    assign flush    = wr_en && (slave_address == ADDRESS_WIDTH'(REG_CTRL))
                      && slave_writedata[CTRL_FLUSH];
    assign data_rd  = rd_en && (slave_address == ADDRESS_WIDTH'(REG_DATA));
    assign last_ch  = (chidx == CW'(NCH - 1));
    assign fifo_pop = data_rd && !fifo_empty && last_ch;
    assign push_req = con_sample_valid && run;
    assign irq_cond = irq_en && ((fifo_level >= thresh) || ovf);

    assign slave_irq      = irq_q;
    assign con_capture_en = run;
    assign unused_wdata   = ^slave_writedata;

    frame_fifo #(
        .WIDTH (FW),
        .AW    (FIFO_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .din     (con_sound_in),
        .pop     (fifo_pop),
        .flush   (flush),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .head    (fifo_head)
    );

    always_comb begin
        ch_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (chidx == CW'(k)) begin
                ch_word = fifo_head[k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH];
            end
        end
    end

    assign data_word = sext ? DATA_WIDTH'($signed(ch_word)) : DATA_WIDTH'(ch_word);

    always_comb begin
        reg_word = '0;
        case (slave_address)
            ADDRESS_WIDTH'(REG_CTRL): begin
                reg_word[CTRL_RUN]    = run;
                reg_word[CTRL_IRQ_EN] = irq_en;
                reg_word[CTRL_SEXT]   = sext;
            end
            ADDRESS_WIDTH'(REG_STATUS): begin
                reg_word[FIFO_WIDTH:0] = fifo_level;
                reg_word[ST_EMPTY]     = fifo_empty;
                reg_word[ST_FULL]      = fifo_full;
                reg_word[ST_OVF]       = ovf;
                reg_word[ST_UDF]       = udf;
                reg_word[ST_IRQ]       = irq_q;
            end
            ADDRESS_WIDTH'(REG_THRESH): reg_word[FIFO_WIDTH:0] = thresh;
            ADDRESS_WIDTH'(REG_CHIDX):  reg_word[CW-1:0]       = chidx;
            default: reg_word = '0;
        endcase
        rd_mux = DATA_WIDTH'(reg_word);
        if (slave_address == ADDRESS_WIDTH'(REG_DATA)) begin
            rd_mux = fifo_empty ? '0 : data_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slave_readdata <= '0;
            run            <= 1'b0;
            irq_en         <= 1'b0;
            sext           <= 1'b0;
            thresh         <= '0;
            ovf            <= 1'b0;
            udf            <= 1'b0;
            irq_q          <= 1'b0;
            chidx          <= '0;
        end else begin
            if (rd_en) begin
                slave_readdata <= rd_mux;
            end
            if (wr_en && (slave_address == ADDRESS_WIDTH'(REG_CTRL))) begin
                run    <= slave_writedata[CTRL_RUN];
                irq_en <= slave_writedata[CTRL_IRQ_EN];
                sext   <= slave_writedata[CTRL_SEXT];
            end
            if (wr_en && (slave_address == ADDRESS_WIDTH'(REG_THRESH))) begin
                thresh <= slave_writedata[FIFO_WIDTH:0];
            end
            // Clear-on-write first so a same-cycle event still leaves the flag set.
            if (wr_en && (slave_address == ADDRESS_WIDTH'(REG_STATUS))) begin
                if (slave_writedata[ST_OVF]) ovf <= 1'b0;
                if (slave_writedata[ST_UDF]) udf <= 1'b0;
            end
            // A push in the flush cycle is discarded, so it cannot overflow.
            if (push_req && fifo_full && !fifo_pop && !flush) begin
                ovf <= 1'b1;
            end
            if (data_rd && fifo_empty) begin
                udf <= 1'b1;
            end
            if (flush) begin
                chidx <= '0;
            end else if (data_rd && !fifo_empty) begin
                chidx <= last_ch ? '0 : chidx + CW'(1);
            end
            irq_q <= irq_cond;
        end
    end

endmodule

// File: tb/tb_audio_capture_mc.sv
module tb_audio_capture_mc;
    localparam int NCH = 2;
    localparam int AUD = 24;
    localparam int DW  = 32;
    localparam int FW  = 2;
    localparam int AW  = 3;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [AW-1:0]     slave_address;
    logic              slave_chipselect;
    logic              slave_read;
    logic              slave_write;
    logic [DW-1:0]     slave_writedata;
    logic [DW-1:0]     slave_readdata;
    logic              slave_irq;
    logic              con_sample_valid;
    logic [NCH*AUD-1:0] con_sound_in;
    logic              con_capture_en;

    audio_capture_mc #(
        .NCH           (NCH),
        .AUD_BIT_DEPTH (AUD),
        .DATA_WIDTH    (DW),
        .FIFO_WIDTH    (FW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .slave_address    (slave_address),
        .slave_chipselect (slave_chipselect),
        .slave_read       (slave_read),
        .slave_write      (slave_write),
        .slave_writedata  (slave_writedata),
        .slave_readdata   (slave_readdata),
        .slave_irq        (slave_irq),
        .con_sample_valid (con_sample_valid),
        .con_sound_in     (con_sound_in),
        .con_capture_en   (con_capture_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model / scoreboard
    logic [NCH*AUD-1:0] sb_q[$];
    int m_chidx = 0;
    int m_thresh = 0;
    bit m_run = 0, m_irq_en = 0, m_sext = 0, m_ovf = 0, m_udf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_irq();
        return m_irq_en && ((sb_q.size() >= m_thresh) || m_ovf);
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_chidx = 0; m_thresh = 0;
        m_run = 0; m_irq_en = 0; m_sext = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_push(input logic [NCH*AUD-1:0] f);
        if (m_run) begin
            if (sb_q.size() < DEPTH) sb_q.push_back(f);
            else m_ovf = 1;
        end
    endtask

    task automatic model_data_read(output logic [31:0] exp);
        logic [NCH*AUD-1:0] f;
        logic [AUD-1:0] ch;
        if (sb_q.size() == 0) begin
            exp = 32'h0;
            m_udf = 1;
        end else begin
            f = sb_q[0];
            ch = f[m_chidx*AUD +: AUD];
            exp = m_sext ? {{(32-AUD){ch[AUD-1]}}, ch} : {{(32-AUD){1'b0}}, ch};
            m_chidx++;
            if (m_chidx == NCH) begin
                m_chidx = 0;
                void'(sb_q.pop_front());
            end
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        slave_address = a; slave_writedata = d;
        slave_chipselect = 1; slave_write = 1;
        cycle();
        slave_chipselect = 0; slave_write = 0;
        case (a)
            0: begin
                m_run = d[0]; m_irq_en = d[1]; m_sext = d[3];
                if (d[2]) begin sb_q.delete(); m_chidx = 0; end
            end
            1: begin
                if (d[18]) m_ovf = 0;
                if (d[19]) m_udf = 0;
            end
            2: m_thresh = int'(d[FW:0]);
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        slave_address = a; slave_chipselect = 1; slave_read = 1;
        cycle();
        slave_chipselect = 0; slave_read = 0;
        d = slave_readdata;
    endtask

    task automatic push_frame(input logic [AUD-1:0] c0, input logic [AUD-1:0] c1);
        con_sound_in = {c1, c0};
        con_sample_valid = 1;
        cycle();
        con_sample_valid = 0;
        model_push({c1, c0});
    endtask

    // DATA read, optionally with a frame strobe in the same cycle
    task automatic read_data(input string tag, input bit with_push,
                             input logic [AUD-1:0] c0, input logic [AUD-1:0] c1);
        logic [31:0] exp;
        slave_address = 3'd3; slave_chipselect = 1; slave_read = 1;
        if (with_push) begin
            con_sound_in = {c1, c0};
            con_sample_valid = 1;
        end
        model_data_read(exp);
        if (with_push) model_push({c1, c0});
        cycle();
        slave_chipselect = 0; slave_read = 0; con_sample_valid = 0;
        chk(tag, slave_readdata, exp);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] got, exp;
        cycle();
        exp = 32'(sb_q.size());
        exp[16] = (sb_q.size() == 0);
        exp[17] = (sb_q.size() == DEPTH);
        exp[18] = m_ovf;
        exp[19] = m_udf;
        exp[20] = m_irq();
        bus_read(3'd1, got);
        chk(tag, got, exp);
    endtask

    task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] got;
        bus_read(a, got);
        chk(tag, got, exp);
    endtask

    initial begin
        reset_n = 0;
        slave_address = '0; slave_chipselect = 0; slave_read = 0; slave_write = 0;
        slave_writedata = '0; con_sample_valid = 0; con_sound_in = '0;
        model_reset();
        cycle(); cycle();
        chk("rst_readdata", slave_readdata, 32'h0);
        chk("rst_irq", 32'(slave_irq), 32'h0);
        chk("rst_capture_en", 32'(con_capture_en), 32'h0);
        reset_n = 1;
        cycle();
        check_status("rst_status");

        // sign-extended capture
        bus_write(3'd0, 32'h9);
        chk("capture_en_on", 32'(con_capture_en), 32'h1);
        push_frame(24'h000001, 24'hFFFFFF);
        push_frame(24'h000002, 24'h800000);
        for (int i = 0; i < 4; i++) read_data("sext_data", 0, '0, '0);
        check_reg("unmapped_rd", 3'd6, 32'h0);
        check_status("sext_drained");
        check_reg("sext_chidx", 3'd4, 32'h0);

        // zero-extended capture and underflow
        bus_write(3'd0, 32'h1);
        push_frame(24'h000001, 24'hFFFFFF);
        push_frame(24'h000002, 24'h800000);
        for (int i = 0; i < 4; i++) read_data("zext_data", 0, '0, '0);
        read_data("udf_data", 0, '0, '0);
        check_status("udf_set");
        bus_write(3'd1, 32'h80000);
        check_status("udf_clr");

        // overflow with depth 4
        for (int i = 1; i <= 5; i++) push_frame(24'(i * 17), 24'(32'h100000 + i));
        check_status("ovf_full");
        for (int i = 0; i < 2 * DEPTH; i++) read_data("ovf_data", 0, '0, '0);
        check_status("ovf_drained");
        bus_write(3'd1, 32'h40000);

        // threshold interrupt
        bus_write(3'd2, 32'h3);
        bus_write(3'd0, 32'h3);
        push_frame(24'h101, 24'h201);
        push_frame(24'h102, 24'h202);
        push_frame(24'h103, 24'h203);
        chk("irq_pre", 32'(slave_irq), 32'h0);
        cycle();
        chk("irq_rise", 32'(slave_irq), 32'h1);
        read_data("irq_data", 0, '0, '0);
        read_data("irq_data", 0, '0, '0);
        chk("irq_hold", 32'(slave_irq), 32'h1);
        cycle();
        chk("irq_fall", 32'(slave_irq), 32'h0);

        // push coincident with final-channel pop while full
        push_frame(24'h104, 24'h204);
        push_frame(24'h105, 24'h205);
        check_status("full_again");
        read_data("pp_data", 0, '0, '0);
        read_data("pp_data", 1, 24'h106, 24'h206);
        check_status("pp_status");
        read_data("pp_data", 0, '0, '0);
        push_frame(24'h107, 24'h207);
        check_status("pp_ovf");
        bus_write(3'd0, 32'h7);
        check_status("flush_status");
        check_reg("flush_ctrl", 3'd0, 32'h3);
        check_reg("flush_chidx", 3'd4, 32'h0);
        bus_write(3'd1, 32'h40000);

        // reset mid-frame
        bus_write(3'd2, 32'h1);
        bus_write(3'd0, 32'hB);
        push_frame(24'h0ABCDE, 24'h012345);
        push_frame(24'h000777, 24'h000888);
        read_data("mid_data", 0, '0, '0);
        check_reg("mid_chidx", 3'd4, 32'h1);
        chk("mid_irq", 32'(slave_irq), 32'h1);
        reset_n = 0;
        cycle();
        model_reset();
        chk("mrst_readdata", slave_readdata, 32'h0);
        chk("mrst_irq", 32'(slave_irq), 32'h0);
        chk("mrst_capture_en", 32'(con_capture_en), 32'h0);
        reset_n = 1;
        check_status("mrst_status");
        check_reg("mrst_ctrl", 3'd0, 32'h0);
        check_reg("mrst_thresh", 3'd2, 32'h0);
        check_reg("mrst_chidx", 3'd4, 32'h0);
        read_data("mrst_data", 0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
